// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, writeback/next-PC/ALU codes, EX register layout and forwarding pick
package id_ex_stage_pkg;
  localparam int XLEN = 32;
  localparam int RADDR_W = 5;
  localparam logic [1:0] WB_ALU = 2'b00, WB_DM = 2'b01, WB_PC4 = 2'b10, WB_IMM = 2'b11;
  localparam logic [2:0] NPC_PC4 = 3'b000, NPC_BR = 3'b001, NPC_JAL = 3'b010, NPC_JALR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100, ALU_SLL = 3'b101, ALU_SRL = 3'b110, ALU_SRA = 3'b111;
  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_e;
  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [2:0]         npc_op;
    logic               brun;
    logic [2:0]         aluop;
    logic               dram_we;
    logic               branch;
    logic               npc_imm_sel;
    logic               rf_we;
    logic               alub_sel;
    logic [1:0]         wb_sel;
    logic [XLEN-1:0]    data_a;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] waddr;
  } ex_t;
  function automatic ex_t bubble();
    bubble = '0;
    bubble.npc_op = NPC_PC4;
  endfunction
  // Youngest producer wins; x0 always reads the register file value.
  function automatic fwd_e fwd_pick(input logic [RADDR_W-1:0] rs, input logic ex_ok,
                                    input logic [RADDR_W-1:0] ex_waddr, input logic mem_we,
                                    input logic [RADDR_W-1:0] mem_waddr, input logic wb_we,
                                    input logic [RADDR_W-1:0] wb_waddr);
    return rs == '0 ? FWD_RF :
           (ex_ok && ex_waddr == rs) ? FWD_EX :
           (mem_we && mem_waddr == rs) ? FWD_MEM :
           (wb_we && wb_waddr == rs) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, bypass sources and EX-stage outputs; counters exist under IDEX_PERF_CNT_EN
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;
  logic [XLEN-1:0]    ID_pc, ID_dataA, ID_rd2, ID_imm;
  logic [2:0]         ID_npc_op, ID_aluop;
  logic               ID_brun, ID_dram_we, ID_branch, ID_npc_imm_sel, ID_rf_we, ID_alub_sel;
  logic [1:0]         ID_wb_sel;
  logic [RADDR_W-1:0] ID_waddr, ID_rs1, ID_rs2;
  logic               ID_rs1_rf, ID_rs2_rf;
  logic               MEM_rf_we, WB_rf_we, EX_flush;
  logic [RADDR_W-1:0] MEM_waddr, WB_waddr;
  logic [XLEN-1:0]    MEM_wdata, WB_wdata, EX_wdata;
  logic               pc_stall, ifid_stall, ifid_flush, EX_valid;
  logic [XLEN-1:0]    EX_pc, EX_dataA, EX_rd2, EX_imm;
  logic [2:0]         EX_npc_op, EX_aluop;
  logic [1:0]         EX_wb_sel;
  logic               EX_brun, EX_dram_we, EX_branch, EX_npc_imm_sel, EX_rf_we, EX_alub_sel;
  logic [RADDR_W-1:0] EX_waddr;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]        stall_cnt, flush_cnt;
`endif
  modport master (
    output ID_pc, ID_dataA, ID_rd2, ID_imm, ID_npc_op, ID_aluop, ID_brun, ID_dram_we, ID_branch,
           ID_npc_imm_sel, ID_rf_we, ID_alub_sel, ID_wb_sel, ID_waddr, ID_rs1, ID_rs2, ID_rs1_rf,
           ID_rs2_rf, MEM_rf_we, WB_rf_we, EX_flush, MEM_waddr, WB_waddr, MEM_wdata, WB_wdata, EX_wdata,
    input  pc_stall, ifid_stall, ifid_flush, EX_valid, EX_pc, EX_dataA, EX_rd2, EX_imm, EX_npc_op,
           EX_aluop, EX_wb_sel, EX_brun, EX_dram_we, EX_branch, EX_npc_imm_sel, EX_rf_we, EX_alub_sel,
`ifdef IDEX_PERF_CNT_EN
           stall_cnt, flush_cnt,
`endif
           EX_waddr
  );
  modport slave (
    input  ID_pc, ID_dataA, ID_rd2, ID_imm, ID_npc_op, ID_aluop, ID_brun, ID_dram_we, ID_branch,
           ID_npc_imm_sel, ID_rf_we, ID_alub_sel, ID_wb_sel, ID_waddr, ID_rs1, ID_rs2, ID_rs1_rf,
           ID_rs2_rf, MEM_rf_we, WB_rf_we, EX_flush, MEM_waddr, WB_waddr, MEM_wdata, WB_wdata, EX_wdata,
    output pc_stall, ifid_stall, ifid_flush, EX_valid, EX_pc, EX_dataA, EX_rd2, EX_imm, EX_npc_op,
           EX_aluop, EX_wb_sel, EX_brun, EX_dram_we, EX_branch, EX_npc_imm_sel, EX_rf_we, EX_alub_sel,
`ifdef IDEX_PERF_CNT_EN
           stall_cnt, flush_cnt,
`endif
           EX_waddr
  );
endinterface

// File: rtl/id_ex_stage_hazard_fwd.sv
// hazard_fwd: combinational operand-source selection, load-use detection and stall/flush requests
module hazard_fwd
  import id_ex_stage_pkg::*;
(
  input  logic               ex_valid_i,
  input  logic               ex_rf_we_i,
  input  logic [1:0]         ex_wb_sel_i,
  input  logic [RADDR_W-1:0] ex_waddr_i,
  input  logic               mem_rf_we_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic               wb_rf_we_i,
  input  logic [RADDR_W-1:0] wb_waddr_i,
  input  logic [RADDR_W-1:0] rs1_i,
  input  logic [RADDR_W-1:0] rs2_i,
  input  logic               rs1_rf_i,
  input  logic               rs2_rf_i,
  input  logic               ex_flush_i,
  output fwd_e               fwd1_sel_o,
  output fwd_e               fwd2_sel_o,
  output logic               luse_o,
  output logic               pc_stall_o,
  output logic               ifid_stall_o,
  output logic               ifid_flush_o
);
  logic ex_wr, ex_ok, ex_ld;
  // A load in EX has no result yet, so it may only stall, never bypass.
  always_comb begin
    ex_wr = ex_valid_i && ex_rf_we_i;
    ex_ok = ex_wr && ex_wb_sel_i != WB_DM;
    ex_ld = ex_wr && ex_wb_sel_i == WB_DM && ex_waddr_i != '0;
    fwd1_sel_o = fwd_pick(rs1_i, ex_ok, ex_waddr_i, mem_rf_we_i, mem_waddr_i, wb_rf_we_i, wb_waddr_i);
    fwd2_sel_o = fwd_pick(rs2_i, ex_ok, ex_waddr_i, mem_rf_we_i, mem_waddr_i, wb_rf_we_i, wb_waddr_i);
    luse_o = ex_ld && ((rs1_rf_i && ex_waddr_i == rs1_i) || (rs2_rf_i && ex_waddr_i == rs2_i));
    pc_stall_o = luse_o && !ex_flush_i;
    ifid_stall_o = pc_stall_o;
    ifid_flush_o = ex_flush_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand bypass, load-use bubble and EX flush; IDEX_PERF_CNT_EN adds stall/flush counters
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  fwd_e            fwd1_sel, fwd2_sel;
  logic            luse;
  logic [XLEN-1:0] op_a, op_b;
  ex_t             ex_q, ex_d;
  hazard_fwd u_hazard_fwd (
    .ex_valid_i  (ex_q.valid),
    .ex_rf_we_i  (ex_q.rf_we),
    .ex_wb_sel_i (ex_q.wb_sel),
    .ex_waddr_i  (ex_q.waddr),
    .mem_rf_we_i (bus.MEM_rf_we),
    .mem_waddr_i (bus.MEM_waddr),
    .wb_rf_we_i  (bus.WB_rf_we),
    .wb_waddr_i  (bus.WB_waddr),
    .rs1_i       (bus.ID_rs1),
    .rs2_i       (bus.ID_rs2),
    .rs1_rf_i    (bus.ID_rs1_rf),
    .rs2_rf_i    (bus.ID_rs2_rf),
    .ex_flush_i  (bus.EX_flush),
    .fwd1_sel_o  (fwd1_sel),
    .fwd2_sel_o  (fwd2_sel),
    .luse_o      (luse),
    .pc_stall_o  (bus.pc_stall),
    .ifid_stall_o(bus.ifid_stall),
    .ifid_flush_o(bus.ifid_flush)
  );
  // Bypassed operands, then either the decoded instruction or a bubble (flush or load-use).
  always_comb begin
    op_a = fwd1_sel == FWD_EX ? bus.EX_wdata : fwd1_sel == FWD_MEM ? bus.MEM_wdata :
           fwd1_sel == FWD_WB ? bus.WB_wdata : bus.ID_dataA;
    op_b = fwd2_sel == FWD_EX ? bus.EX_wdata : fwd2_sel == FWD_MEM ? bus.MEM_wdata :
           fwd2_sel == FWD_WB ? bus.WB_wdata : bus.ID_rd2;
    ex_d = bubble();
    if (!bus.EX_flush && !luse)
      ex_d = '{valid: 1'b1, pc: bus.ID_pc, npc_op: bus.ID_npc_op, brun: bus.ID_brun,
               aluop: bus.ID_aluop, dram_we: bus.ID_dram_we, branch: bus.ID_branch,
               npc_imm_sel: bus.ID_npc_imm_sel, rf_we: bus.ID_rf_we, alub_sel: bus.ID_alub_sel,
               wb_sel: bus.ID_wb_sel, data_a: op_a, rd2: op_b, imm: bus.ID_imm, waddr: bus.ID_waddr};
  end
  // EX register bank.
  always_ff @(posedge clk or posedge rst)
    if (rst) ex_q <= bubble();
    else ex_q <= ex_d;
  assign bus.EX_valid       = ex_q.valid;
  assign bus.EX_pc          = ex_q.pc;
  assign bus.EX_npc_op      = ex_q.npc_op;
  assign bus.EX_brun        = ex_q.brun;
  assign bus.EX_aluop       = ex_q.aluop;
  assign bus.EX_dram_we     = ex_q.dram_we;
  assign bus.EX_branch      = ex_q.branch;
  assign bus.EX_npc_imm_sel = ex_q.npc_imm_sel;
  assign bus.EX_rf_we       = ex_q.rf_we;
  assign bus.EX_alub_sel    = ex_q.alub_sel;
  assign bus.EX_wb_sel      = ex_q.wb_sel;
  assign bus.EX_dataA       = ex_q.data_a;
  assign bus.EX_rd2         = ex_q.rd2;
  assign bus.EX_imm         = ex_q.imm;
  assign bus.EX_waddr       = ex_q.waddr;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  // Saturating event counters.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.pc_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.EX_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: reference model of the ID/EX stage checked every cycle, plus directed literal checks
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic clk, rst;
  int   total = 0, bad = 0;
  id_ex_stage_if bus();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic        valid, brun, dram_we, branch, nis, rf_we, alub_sel;
    logic [2:0]  npc_op, aluop;
    logic [1:0]  wb_sel;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  waddr;
  } mdl_t;
  mdl_t m;
  int unsigned m_sc = 0, m_fc = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic m_luse();
    return m.valid && m.rf_we && m.wb_sel == WB_DM && m.waddr != 0 &&
           ((bus.ID_rs1_rf && m.waddr == bus.ID_rs1) || (bus.ID_rs2_rf && m.waddr == bus.ID_rs2));
  endfunction
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (m.valid && m.rf_we && m.wb_sel != WB_DM && m.waddr == rs) return bus.EX_wdata;
    if (bus.MEM_rf_we && bus.MEM_waddr == rs) return bus.MEM_wdata;
    if (bus.WB_rf_we && bus.WB_waddr == rs) return bus.WB_wdata;
    return rf;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '{default: '0};
      m_sc <= 0;
      m_fc <= 0;
    end else begin
      if (bus.EX_flush) m_fc <= m_fc + 1;
      else if (m_luse()) m_sc <= m_sc + 1;
      if (bus.EX_flush || m_luse()) m <= '{default: '0};
      else m <= '{valid: 1'b1, brun: bus.ID_brun, dram_we: bus.ID_dram_we, branch: bus.ID_branch,
                  nis: bus.ID_npc_imm_sel, rf_we: bus.ID_rf_we, alub_sel: bus.ID_alub_sel,
                  npc_op: bus.ID_npc_op, aluop: bus.ID_aluop, wb_sel: bus.ID_wb_sel, pc: bus.ID_pc,
                  a: m_fwd(bus.ID_rs1, bus.ID_dataA), b: m_fwd(bus.ID_rs2, bus.ID_rd2),
                  imm: bus.ID_imm, waddr: bus.ID_waddr};
    end
  end
  always @(negedge clk) begin
    chk("ctrl", {12'd0, bus.EX_valid, bus.EX_npc_op, bus.EX_brun, bus.EX_aluop, bus.EX_dram_we,
                 bus.EX_branch, bus.EX_npc_imm_sel, bus.EX_rf_we, bus.EX_alub_sel, bus.EX_wb_sel, bus.EX_waddr},
        {12'd0, m.valid, m.npc_op, m.brun, m.aluop, m.dram_we, m.branch, m.nis, m.rf_we,
         m.alub_sel, m.wb_sel, m.waddr});
    chk("pc", bus.EX_pc, m.pc);
    chk("dataA", bus.EX_dataA, m.a);
    chk("rd2", bus.EX_rd2, m.b);
    chk("imm", bus.EX_imm, m.imm);
    chk("stall_flush", {29'd0, bus.pc_stall, bus.ifid_stall, bus.ifid_flush},
        {29'd0, m_luse() && !bus.EX_flush, m_luse() && !bus.EX_flush, bus.EX_flush});
`ifdef IDEX_PERF_CNT_EN
    chk("stall_cnt", bus.stall_cnt, m_sc);
    chk("flush_cnt", bus.flush_cnt, m_fc);
`endif
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {bus.ID_pc, bus.ID_dataA, bus.ID_rd2, bus.ID_imm} = '0;
    {bus.ID_npc_op, bus.ID_aluop, bus.ID_wb_sel} = '0;
    {bus.ID_brun, bus.ID_dram_we, bus.ID_branch, bus.ID_npc_imm_sel, bus.ID_rf_we, bus.ID_alub_sel} = '0;
    {bus.ID_waddr, bus.ID_rs1, bus.ID_rs2, bus.ID_rs1_rf, bus.ID_rs2_rf} = '0;
    {bus.MEM_rf_we, bus.MEM_waddr, bus.MEM_wdata, bus.WB_rf_we, bus.WB_waddr, bus.WB_wdata} = '0;
    {bus.EX_wdata, bus.EX_flush} = '0;
  endtask
  task automatic id_op(input logic [31:0] pc, input logic [1:0] wb, input logic we, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic r1, input logic r2,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    bus.ID_pc = pc; bus.ID_wb_sel = wb; bus.ID_rf_we = we; bus.ID_waddr = rd;
    bus.ID_rs1 = rs1; bus.ID_rs2 = rs2; bus.ID_rs1_rf = r1; bus.ID_rs2_rf = r2;
    bus.ID_dataA = a; bus.ID_rd2 = b; bus.ID_imm = imm;
  endtask
  initial begin
    logic [31:0] fc0;
    rst = 1'b1;
    clr();
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, bus.EX_valid}, 32'd0);
    chk("rst_npc_op", {29'd0, bus.EX_npc_op}, {29'd0, NPC_PC4});
    chk("rst_stall", {31'd0, bus.pc_stall}, 32'd0);
    // addi x5, x1, 0x10
    id_op(32'h40, WB_ALU, 1, 5, 1, 0, 1, 0, 32'h100, 0, 32'h10);
    bus.ID_alub_sel = 1; bus.ID_aluop = ALU_ADD;
    step();
    chk("addi_valid", {31'd0, bus.EX_valid}, 32'd1);
    chk("addi_pc", bus.EX_pc, 32'h40);
    chk("addi_dataA", bus.EX_dataA, 32'h100);
    // EX bypass beats MEM bypass
    bus.EX_wdata = 32'h10; bus.MEM_rf_we = 1; bus.MEM_waddr = 5; bus.MEM_wdata = 32'h20;
    id_op(32'h44, WB_ALU, 1, 6, 5, 3, 1, 1, 32'h999, 32'h3, 0);
    bus.ID_alub_sel = 0;
    step();
    chk("ex_fwd", bus.EX_dataA, 32'h10);
    chk("ex_fwd_rd2", bus.EX_rd2, 32'h3);
    // MEM on rs1, WB on rs2, MEM beats WB
    clr();
    bus.MEM_rf_we = 1; bus.MEM_waddr = 9; bus.MEM_wdata = 32'h55;
    bus.WB_rf_we = 1; bus.WB_waddr = 12; bus.WB_wdata = 32'h77;
    id_op(32'h48, WB_ALU, 1, 13, 9, 12, 1, 1, 32'h1, 32'h2, 0);
    step();
    chk("mem_fwd", bus.EX_dataA, 32'h55);
    chk("wb_fwd", bus.EX_rd2, 32'h77);
    bus.WB_waddr = 9; bus.WB_wdata = 32'h66;
    id_op(32'h4c, WB_ALU, 1, 14, 9, 0, 1, 0, 32'h1, 32'h2, 0);
    step();
    chk("mem_over_wb", bus.EX_dataA, 32'h55);
    // x0 guard: EX writes x0
    clr();
    id_op(32'h50, WB_ALU, 1, 0, 0, 0, 1, 0, 0, 0, 32'hFF);
    step();
    bus.EX_wdata = 32'hFF;
    id_op(32'h54, WB_ALU, 1, 8, 0, 0, 1, 1, 0, 0, 0);
    #1;
    chk("x0_nostall", {31'd0, bus.pc_stall}, 32'd0);
    step();
    chk("x0_dataA", bus.EX_dataA, 32'h0);
    // load-use: lw x7 then add x8, x1, x7
    clr();
    id_op(32'h60, WB_DM, 1, 7, 2, 0, 1, 0, 32'h1000, 0, 32'h4);
    step();
    id_op(32'h64, WB_ALU, 1, 8, 1, 7, 1, 1, 32'h1, 32'h111, 0);
    #1;
    chk("lu_pc_stall", {31'd0, bus.pc_stall}, 32'd1);
    chk("lu_ifid_stall", {31'd0, bus.ifid_stall}, 32'd1);
    step();
    chk("lu_bubble", {30'd0, bus.EX_valid, bus.EX_rf_we}, 32'd0);
    chk("lu_released", {31'd0, bus.pc_stall}, 32'd0);
    bus.MEM_rf_we = 1; bus.MEM_waddr = 7; bus.MEM_wdata = 32'hDEADBEEF;
    step();
    chk("lu_mem_fwd", bus.EX_rd2, 32'hDEADBEEF);
    chk("lu_valid", {31'd0, bus.EX_valid}, 32'd1);
    // no false stall: lui with rs1 field = 7
    clr();
    id_op(32'h70, WB_DM, 1, 7, 2, 0, 1, 0, 0, 0, 0);
    step();
    id_op(32'h74, WB_IMM, 1, 9, 7, 7, 0, 0, 0, 0, 32'h12345000);
    #1;
    chk("lui_nostall", {31'd0, bus.pc_stall}, 32'd0);
    step();
    chk("lui_valid", {31'd0, bus.EX_valid}, 32'd1);
    chk("lui_imm", bus.EX_imm, 32'h12345000);
    // flush while ID holds sw
    clr();
    id_op(32'h80, WB_ALU, 0, 0, 3, 4, 1, 1, 32'h200, 32'h5, 32'h8);
    bus.ID_dram_we = 1; bus.EX_flush = 1;
    fc0 = 0;
`ifdef IDEX_PERF_CNT_EN
    fc0 = bus.flush_cnt;
`endif
    #1;
    chk("fl_ifid_flush", {31'd0, bus.ifid_flush}, 32'd1);
    step();
    chk("fl_bubble", {30'd0, bus.EX_valid, bus.EX_dram_we}, 32'd0);
`ifdef IDEX_PERF_CNT_EN
    chk("fl_cnt", bus.flush_cnt, fc0 + 1);
`endif
    // flush coincident with load-use suppresses the stall
    clr();
    id_op(32'h90, WB_DM, 1, 7, 2, 0, 1, 0, 0, 0, 0);
    step();
    id_op(32'h94, WB_ALU, 1, 8, 7, 0, 1, 0, 0, 0, 0);
    bus.EX_flush = 1;
    #1;
    chk("fl_lu_nostall", {30'd0, bus.pc_stall, bus.ifid_flush}, 32'd1);
    step();
    chk("fl_lu_bubble", {31'd0, bus.EX_valid}, 32'd0);
    // reset in the middle of a stall
    clr();
    id_op(32'hA0, WB_DM, 1, 7, 2, 0, 1, 0, 0, 0, 32'h4);
    step();
    id_op(32'hA4, WB_ALU, 1, 8, 7, 0, 1, 0, 0, 0, 0);
    #1;
    chk("rs_stall_on", {31'd0, bus.pc_stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rs_stall_off", {31'd0, bus.pc_stall}, 32'd0);
    chk("rs_ex_clear", {bus.EX_pc[15:0], 10'd0, bus.EX_valid, bus.EX_waddr}, 32'd0);
    step();
    rst = 1'b0;
    // asynchronous reset while EX holds a valid addi
    clr();
    id_op(32'hB0, WB_ALU, 1, 5, 1, 0, 1, 0, 32'h33, 0, 32'h10);
    step();
    chk("ra_valid", {31'd0, bus.EX_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ra_ctrl", {20'd0, bus.EX_valid, bus.EX_rf_we, bus.EX_npc_op, bus.EX_wb_sel, bus.EX_waddr}, 32'd0);
    chk("ra_data", bus.EX_pc | bus.EX_dataA | bus.EX_imm, 32'd0);
    step();
    rst = 1'b0;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Sits between instruction decode and execute in the 5-stage pipeline.
- Registers all decode-stage control/data into the EX stage and forwards EX/MEM/WB results onto the rs1/rs2 operands before capture.
- Detects load-use hazards: stalls PC and IF/ID, inserts a bubble into EX.
- Applies branch/jump flush from EX.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous active-high reset.
- ID_pc  in  XLEN  PC of decode-stage instruction.
- ID_npc_op  in  3  next-PC op.
- ID_brun  in  1  unsigned-branch compare.
- ID_aluop  in  3  ALU op.
- ID_dram_we  in  1  data RAM write.
- ID_branch  in  1  instruction is a branch.
- ID_npc_imm_sel  in  1  NPC immediate select.
- ID_rf_we  in  1  register write.
- ID_alub_sel  in  1  ALU B select.
- ID_wb_sel  in  2  writeback select.
- ID_dataA, ID_rd2  in  XLEN  regfile read data.
- ID_imm  in  XLEN  sign-extended immediate.
- ID_waddr, ID_rs1, ID_rs2  in  RADDR_W  register addresses.
- ID_rs1_rf, ID_rs2_rf  in  1  instruction really reads rs1/rs2.
- MEM_rf_we  in  1  MEM-stage register write.
- MEM_waddr  in  RADDR_W  MEM-stage destination.
- MEM_wdata  in  XLEN  MEM-stage final writeback value.
- WB_rf_we  in  1  WB-stage register write.
- WB_waddr  in  RADDR_W  WB-stage destination.
- WB_wdata  in  XLEN  WB-stage writeback value.
- EX_wdata  in  XLEN  EX-stage non-load result, from the EX writeback mux.
- EX_flush  in  1  branch taken or jump resolved in EX.
- pc_stall, ifid_stall  out  1  hold PC / IF-ID register.
- ifid_flush  out  1  clear IF-ID register.
- EX_valid  out  1  EX slot holds a real instruction.
- EX_pc, EX_dataA, EX_rd2, EX_imm  out  XLEN  registered copies.
- EX_npc_op, EX_aluop  out  3  registered copies.
- EX_wb_sel  out  2  registered copy.
- EX_brun, EX_dram_we, EX_branch, EX_npc_imm_sel, EX_rf_we, EX_alub_sel  out  1  registered copies.
- EX_waddr  out  RADDR_W  registered copy.

Behaviour:
- **Reset** (async, rst=1): every EX_* output and EX_valid = 0. EX_npc_op resets to NPC_PC4. pc_stall, ifid_stall and ifid_flush follow their combinational equations, which evaluate to 0 once EX is cleared.
- **Forwarding** (combinational, per operand, shown for rs1; rs2 is identical):
  - Source = EX if EX_valid && EX_rf_we && EX_waddr==ID_rs1 && EX_wb_sel!=WB_DM.
  - Else MEM if MEM_rf_we && MEM_waddr==ID_rs1.
  - Else WB if WB_rf_we && WB_waddr==ID_rs1.
  - Else ID_dataA.
  - Address 0 is never forwarded.
  - The forwarded value is what EX_dataA / EX_rd2 capture.
- **Load-use**: luse = EX_valid && EX_rf_we && EX_wb_sel==WB_DM && EX_waddr!=0 && ((ID_rs1_rf && EX_waddr==ID_rs1) || (ID_rs2_rf && EX_waddr==ID_rs2)).
- **Outputs**:
  - pc_stall = ifid_stall = luse && !EX_flush.
  - ifid_flush = EX_flush.
- **Register update** (posedge), priority order:
  1. EX_flush: bubble.
  2. luse: bubble.
  3. Otherwise: capture ID values, EX_valid=1.
- **Bubble**: EX_valid=0; EX_rf_we=0, EX_dram_we=0, EX_branch=0, EX_npc_op=NPC_PC4. Data fields are don't-care but hold 0.
- **Latency**: one cycle from ID to EX. A load-use hazard costs exactly one bubble; on the following cycle the load is in MEM and the value comes over the MEM path.
- **Simultaneous flush and load-use** cannot occur architecturally, since the EX instruction is either a branch/jump or a load. Flush still has priority and suppresses the stall.
- **Reset mid-stall**: stall drops immediately because EX_valid=0.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- When defined, adds:
  - output stall_cnt  32: count of cycles with luse && !EX_flush.
  - output flush_cnt  32: count of cycles with EX_flush.
- Both counters reset to 0 asynchronously and saturate at 0xFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared include param.v holds:
  - WB_ALU=2'b00, WB_DM=2'b01, WB_PC4=2'b10, WB_IMM=2'b11.
  - NPC_PC4=3'b000 and the remaining NPC op codes.
  - ALU op codes.
- Sub-module hazard_fwd (purely combinational) produces the two forwarding selects, luse and the stall/flush outputs. id_ex_stage holds the register bank and the operand muxes.

Test Plan:
- **Reset/hold**: assert rst mid-run with EX holding valid addi -> all EX_* =0 and EX_valid=0 asynchronously, before the next clk edge.
- **EX forward**: EX holds addi x5 (EX_wdata=0x10), MEM writes x5=0x20, ID reads rs1=x5 -> EX_dataA=0x10 next cycle (EX priority over MEM).
- **x0 guard**: EX_rf_we=1, EX_waddr=0, EX_wdata=0xFF, ID rs1=x0, ID_dataA=0 -> EX_dataA=0 and no stall.
- **Load-use**: EX holds lw x7 (wb_sel=WB_DM), ID holds add rs2=x7 with rs2_rf=1 -> pc_stall=ifid_stall=1 for one cycle, then EX_valid=0 bubble. The next cycle's add captures MEM_wdata=0xDEADBEEF into EX_rd2.
- **No false stall**: same as the load-use case but ID is lui (rs1_rf=rs2_rf=0) with bits[19:15]=7 -> no stall, EX_valid=1.
- **Flush**: EX_flush=1 while ID holds sw -> ifid_flush=1; next cycle EX_valid=0 and EX_dram_we=0. Under IDEX_PERF_CNT_EN, flush_cnt increments by 1.
